// File: rtl/wb_scoreboard_pkg.sv
// Shared definitions for the writeback scoreboard: register-file geometry,
// address/data types and a one-hot helper for the pending mask.
package wb_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xdata_t;

    // One-hot mask for a register; x0 is hardwired to zero so it never
    // gets a pending bit.
    function automatic logic [NUM_REGS-1:0] reg_bit(input reg_addr_t a);
        reg_bit = '0;
        if (a != '0) begin
            reg_bit[a] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/wb_scoreboard_result_buf.sv
// result_buf: one-entry valid/ready holding register for mul/div results.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid_i       producer offers a result
//   in_rd_i/in_data_i  offered destination and value
//   in_ready_o       result accepted when in_valid_i && in_ready_o
//   out_take_i       consumer drains the held entry at this edge
//   out_valid_o      entry is occupied
//   out_rd_o/out_data_o  held destination and value
module result_buf
    import wb_scoreboard_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      in_valid_i,
    input  reg_addr_t in_rd_i,
    input  xdata_t    in_data_i,
    output logic      in_ready_o,
    input  logic      out_take_i,
    output logic      out_valid_o,
    output reg_addr_t out_rd_o,
    output xdata_t    out_data_o
);

    logic      valid_q, valid_d;
    reg_addr_t rd_q;
    xdata_t    data_q;
    logic      accept;

    // A draining entry frees the slot in the same cycle, so a new result can
    // be taken every cycle while the consumer keeps draining.
    assign in_ready_o = !rst && (!valid_q || out_take_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        valid_d = valid_q;
        if (accept) begin
            valid_d = 1'b1;
        end else if (out_take_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset: it is only observed while valid_q is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q   <= in_rd_i;
            data_q <= in_data_i;
        end
    end

    assign out_valid_o = valid_q;
    assign out_rd_o    = rd_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: tracks destinations of in-flight mul/div ops, stalls decode
// on RAW/WAW hazards or a full long-op window, and arbitrates the single
// register-file write port between pipeline writeback and buffered mul/div
// results (pipeline writeback wins).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   issue_valid/issue_rd/issue_long  instruction issuing from decode
//   dec_rs1/dec_rs2, dec_use_rs1/dec_use_rs2  decode source operands
//   wb_valid/wb_rd/wb_data        pipeline writeback (never back-pressured)
//   md_valid/md_rd/md_data, md_ready  mul/div result handshake
//   stall                         decode must hold this cycle
//   rf_we/rf_waddr/rf_wd          register-file write port
//   pending                       per-register long-op in-flight mask
module wb_scoreboard
    import wb_scoreboard_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_long,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  dec_use_rs1,
    input  logic                  dec_use_rs2,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_rd,
    input  logic [XLEN-1:0]       md_data,
    output logic                  md_ready,
    output logic                  stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wd,
    output logic [NUM_REGS-1:0]   pending
);

    localparam int              CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;

    logic      buf_valid;
    reg_addr_t buf_rd;
    xdata_t    buf_data;
    logic      wb_hit, drain, long_issue;
    logic      raw1, raw2, waw, full;

    result_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (md_valid),
        .in_rd_i     (md_rd),
        .in_data_i   (md_data),
        .in_ready_o  (md_ready),
        .out_take_i  (drain),
        .out_valid_o (buf_valid),
        .out_rd_o    (buf_rd),
        .out_data_o  (buf_data)
    );

    // Hazard detection against the registered pending mask.
    assign raw1  = dec_use_rs1 && (dec_rs1 != '0) && pending_q[dec_rs1];
    assign raw2  = dec_use_rs2 && (dec_rs2 != '0) && pending_q[dec_rs2];
    assign waw   = issue_valid && (issue_rd != '0) && pending_q[issue_rd];
    assign full  = issue_valid && issue_long && (out_cnt_q == MAX_CNT);
    assign stall = !rst && (raw1 || raw2 || waw || full);

    assign long_issue = issue_valid && issue_long && !stall && !rst;

    // Write-port arbitration: a writeback to x0 does not occupy the port, so
    // the buffer may drain underneath it.
    assign wb_hit = wb_valid && (wb_rd != '0) && !rst;
    assign drain  = buf_valid && !wb_hit && !rst;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = buf_rd;
        rf_wd    = buf_data;
        if (wb_hit) begin
            rf_we    = 1'b1;
            rf_waddr = wb_rd;
            rf_wd    = wb_data;
        end else if (drain && (buf_rd != '0)) begin
            rf_we = 1'b1;
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (drain) begin
            pending_d = pending_d & ~reg_bit(buf_rd);
        end
        // Set is applied after clear so a same-register collision keeps the bit.
        if (long_issue) begin
            pending_d = pending_d | reg_bit(issue_rd);
        end
    end

    // A drain with an empty window can only come from a stray result; the
    // counter floors at zero instead of wrapping.
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (long_issue && !drain) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (drain && !long_issue && (out_cnt_q != '0)) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            out_cnt_q <= '0;
        end else begin
            pending_q <= pending_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign pending = pending_q;

    // A mul/div result for a register with no long op in flight is a
    // protocol error upstream; it is still written.
    a_md_rd_pending: assert property (@(posedge clk) disable iff (rst)
        (md_valid && md_ready && (md_rd != '0)) |-> pending_q[md_rd]);

endmodule

// File: tb/tb_wb_scoreboard.sv
module tb_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_long;
    logic [4:0]  issue_rd, dec_rs1, dec_rs2;
    logic        dec_use_rs1, dec_use_rs2;
    logic        wb_valid, md_valid;
    logic [4:0]  wb_rd, md_rd;
    logic [31:0] wb_data, md_data;
    logic        md_ready, stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wd;
    logic [31:0] pending;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  passed = 0;

    always #5 clk = ~clk;

    wb_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_long(issue_long),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
        .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wd(rf_wd),
        .pending(pending)
    );

    // Scoreboard: every register-file write must match the oldest expected one.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write got waddr=%0d wd=%h expected no write", rf_waddr, rf_wd);
            end else begin
                e = exp_q.pop_front();
                if (rf_waddr !== e.a || rf_wd !== e.d)
                    $display("FAIL rf_write got waddr=%0d wd=%h expected waddr=%0d wd=%h", rf_waddr, rf_wd, e.a, e.d);
                else
                    passed++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_long = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        md_valid = 0; md_rd = 0; md_data = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        step(); step();
        wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h1234;
        issue_valid = 1; issue_long = 1; issue_rd = 5'd4;
        #1;
        checks++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we got=%b expected=0", rf_we); else passed++;
        checks++; if (md_ready !== 1'b0) $display("FAIL reset_md_ready got=%b expected=0", md_ready); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b expected=0", stall); else passed++;
        step();
        idle();
        #1;
        checks++; if (pending !== 32'h0) $display("FAIL reset_pending got=%h expected=0", pending); else passed++;
        checks++; if (int'(dut.out_cnt_q) != 0) $display("FAIL reset_out_cnt got=%0d expected=0", dut.out_cnt_q); else passed++;
        rst = 0;
        step();
    endtask

    task automatic test_raw();
        issue_valid = 1; issue_long = 1; issue_rd = 5'd5;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL raw_issue_stall got=%b expected=0", stall); else passed++;
        step();
        idle(); dec_use_rs1 = 1; dec_rs1 = 5'd5;
        #1;
        checks++; if (pending !== 32'h20) $display("FAIL raw_pending got=%h expected=00000020", pending); else passed++;
        checks++; if (stall !== 1'b1) $display("FAIL raw_stall got=%b expected=1", stall); else passed++;
        step();
        md_valid = 1; md_rd = 5'd5; md_data = 32'h2A;
        exp_q.push_back(wr_t'{5'd5, 32'h2A});
        #1;
        checks++; if (md_ready !== 1'b1) $display("FAIL raw_md_ready got=%b expected=1", md_ready); else passed++;
        checks++; if (stall !== 1'b1) $display("FAIL raw_stall_md got=%b expected=1", stall); else passed++;
        step();
        md_valid = 0;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5) $display("FAIL raw_drain got we=%b waddr=%0d expected we=1 waddr=5", rf_we, rf_waddr); else passed++;
        checks++; if (stall !== 1'b1) $display("FAIL raw_stall_drain got=%b expected=1", stall); else passed++;
        step();
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL raw_stall_after got=%b expected=0", stall); else passed++;
        checks++; if (pending !== 32'h0) $display("FAIL raw_pending_after got=%h expected=0", pending); else passed++;
        idle();
        step();
    endtask

    task automatic test_wb_priority();
        issue_valid = 1; issue_long = 1; issue_rd = 5'd7;
        step();
        idle();
        wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h11;
        md_valid = 1; md_rd = 5'd7; md_data = 32'h77;
        exp_q.push_back(wr_t'{5'd3, 32'h11});
        exp_q.push_back(wr_t'{5'd7, 32'h77});
        #1;
        checks++; if (md_ready !== 1'b1) $display("FAIL prio_md_ready_n got=%b expected=1", md_ready); else passed++;
        checks++; if (rf_waddr !== 5'd3) $display("FAIL prio_waddr_n got=%0d expected=3", rf_waddr); else passed++;
        step();
        idle();
        #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7) $display("FAIL prio_waddr_n1 got we=%b waddr=%0d expected we=1 waddr=7", rf_we, rf_waddr); else passed++;
        checks++; if (md_ready !== 1'b1) $display("FAIL prio_md_ready_n1 got=%b expected=1", md_ready); else passed++;
        step();
        checks++; if (pending !== 32'h0 || int'(dut.out_cnt_q) != 0) $display("FAIL prio_final got pending=%h cnt=%0d expected 0/0", pending, dut.out_cnt_q); else passed++;
    endtask

    task automatic test_max_out();
        for (int r = 1; r <= 4; r++) begin
            issue_valid = 1; issue_long = 1; issue_rd = 5'(r);
            #1;
            checks++; if (stall !== 1'b0) $display("FAIL max_issue_stall rd=%0d got=%b expected=0", r, stall); else passed++;
            step();
        end
        issue_rd = 5'd9;
        md_valid = 1; md_rd = 5'd1; md_data = 32'hA1;
        exp_q.push_back(wr_t'{5'd1, 32'hA1});
        #1;
        checks++; if (int'(dut.out_cnt_q) != 4) $display("FAIL max_cnt_full got=%0d expected=4", dut.out_cnt_q); else passed++;
        checks++; if (stall !== 1'b1) $display("FAIL max_stall_full got=%b expected=1", stall); else passed++;
        step();
        md_valid = 0;
        #1;
        checks++; if (stall !== 1'b1) $display("FAIL max_stall_drain got=%b expected=1", stall); else passed++;
        step();
        checks++; if (stall !== 1'b0) $display("FAIL max_stall_freed got=%b expected=0", stall); else passed++;
        step();
        issue_valid = 0; issue_long = 0; issue_rd = 0;
        checks++; if (int'(dut.out_cnt_q) != 4) $display("FAIL max_cnt_back got=%0d expected=4", dut.out_cnt_q); else passed++;
        checks++; if (pending !== 32'h21C) $display("FAIL max_pending got=%h expected=0000021c", pending); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] rds [4];
        rds[0] = 5'd2; rds[1] = 5'd3; rds[2] = 5'd4; rds[3] = 5'd9;
        for (int i = 0; i < 4; i++) begin
            md_valid = 1; md_rd = rds[i]; md_data = 32'hB00 + 32'(i);
            exp_q.push_back(wr_t'{rds[i], 32'hB00 + 32'(i)});
            #1;
            checks++; if (md_ready !== 1'b1) $display("FAIL b2b_md_ready i=%0d got=%b expected=1", i, md_ready); else passed++;
            step();
        end
        idle();
        step(); step();
        checks++; if (pending !== 32'h0 || int'(dut.out_cnt_q) != 0) $display("FAIL b2b_final got pending=%h cnt=%0d expected 0/0", pending, dut.out_cnt_q); else passed++;
        checks++; if (exp_q.size() != 0) $display("FAIL b2b_missing_writes got=%0d expected=0", exp_q.size()); else passed++;
    endtask

    task automatic test_rd0();
        wb_valid = 1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        issue_valid = 1; issue_long = 1; issue_rd = 5'd0;
        #1;
        checks++; if (rf_we !== 1'b0) $display("FAIL rd0_wb_we got=%b expected=0", rf_we); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL rd0_stall got=%b expected=0", stall); else passed++;
        step();
        idle();
        md_valid = 1; md_rd = 5'd0; md_data = 32'h5;
        #1;
        checks++; if (pending !== 32'h0) $display("FAIL rd0_pending got=%h expected=0", pending); else passed++;
        checks++; if (int'(dut.out_cnt_q) != 1) $display("FAIL rd0_cnt_inc got=%0d expected=1", dut.out_cnt_q); else passed++;
        step();
        md_valid = 0;
        #1;
        checks++; if (rf_we !== 1'b0) $display("FAIL rd0_drain_we got=%b expected=0", rf_we); else passed++;
        step();
        checks++; if (int'(dut.out_cnt_q) != 0) $display("FAIL rd0_cnt_dec got=%0d expected=0", dut.out_cnt_q); else passed++;
    endtask

    task automatic test_reset_mid();
        issue_valid = 1; issue_long = 1; issue_rd = 5'd6;
        step();
        issue_rd = 5'd11;
        step();
        idle();
        md_valid = 1; md_rd = 5'd6; md_data = 32'h66;
        wb_valid = 1; wb_rd = 5'd12; wb_data = 32'hC;
        exp_q.push_back(wr_t'{5'd12, 32'hC});
        step();
        idle();
        rst = 1;
        #1;
        checks++; if (pending !== 32'h840 || int'(dut.out_cnt_q) != 2) $display("FAIL rstmid_before got pending=%h cnt=%0d expected 00000840/2", pending, dut.out_cnt_q); else passed++;
        checks++; if (rf_we !== 1'b0) $display("FAIL rstmid_we got=%b expected=0", rf_we); else passed++;
        step();
        rst = 0;
        #1;
        checks++; if (pending !== 32'h0 || int'(dut.out_cnt_q) != 0) $display("FAIL rstmid_after got pending=%h cnt=%0d expected 0/0", pending, dut.out_cnt_q); else passed++;
        checks++; if (md_ready !== 1'b1) $display("FAIL rstmid_md_ready got=%b expected=1", md_ready); else passed++;
        checks++; if (rf_we !== 1'b0) $display("FAIL rstmid_after_we got=%b expected=0", rf_we); else passed++;
        step();
    endtask

    task automatic test_issue_drain();
        issue_valid = 1; issue_long = 1; issue_rd = 5'd2;
        step();
        idle();
        md_valid = 1; md_rd = 5'd2; md_data = 32'h22;
        exp_q.push_back(wr_t'{5'd2, 32'h22});
        step();
        md_valid = 0;
        issue_valid = 1; issue_long = 1; issue_rd = 5'd8;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL isdr_stall got=%b expected=0", stall); else passed++;
        step();
        idle();
        checks++; if (int'(dut.out_cnt_q) != 1) $display("FAIL isdr_cnt got=%0d expected=1", dut.out_cnt_q); else passed++;
        checks++; if (pending !== 32'h100) $display("FAIL isdr_pending got=%h expected=00000100", pending); else passed++;
        md_valid = 1; md_rd = 5'd8; md_data = 32'h88;
        exp_q.push_back(wr_t'{5'd8, 32'h88});
        step();
        idle();
        step();
        checks++; if (pending !== 32'h0 || exp_q.size() != 0) $display("FAIL isdr_final got pending=%h queued=%0d expected 0/0", pending, exp_q.size()); else passed++;
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_raw();
        test_wb_priority();
        test_max_out();
        test_back_to_back();
        test_rd0();
        test_reset_mid();
        test_issue_drain();
        step(); step();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
